keypad_lock: RTL
================

# keypad_lock

Parametrised keypad code-lock controller: consumes one-cycle digit strobes from the keyboard scanner, compares an N-digit entry against a stored code, and drives clean (never high-Z) unlock / fail indications for a fixed hold time. Adds failure counting with timed lockout, an inter-digit entry timeout, and an optional runtime code-change mode. Sits between the keyboard decoder and the LED/actuator logic.

## Interface
- CODE_LEN, 3: digits per code (≥1)
- DIGIT_W, 4: bits per digit
- CODE, 12'h015: reset/default code, CODE_LEN*DIGIT_W bits, first digit in MSBs
- HOLD_CYCLES, 200: cycles unlock or fail is held (≥1)
- TIMEOUT_CYCLES, 1000: max idle cycles between digits during entry (≥1)
- MAX_FAIL, 3: consecutive failures that trigger lockout (≥1)
- LOCKOUT_CYCLES, 5000: lockout duration (≥1)
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- key_valid  in  1  one-cycle strobe, key_num valid
- key_num  in  DIGIT_W  digit value
- prog_req  in  1  one-cycle request to change code (used only with KEYPAD_LOCK_PROG_EN)
- unlock  out  1  high for HOLD_CYCLES after correct entry
- fail  out  1  high for HOLD_CYCLES after wrong entry
- locked_out  out  1  high during lockout
- prog_busy  out  1  high while collecting a new code
- digit_cnt  out  $clog2(CODE_LEN+1)  digits accepted in current entry
- fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failures

## Operation
- States: IDLE, ENTRY, OPEN, FAIL, LOCKOUT, PROG.
- IDLE: key_valid → compare digit 0, digit_cnt=1, go ENTRY (or straight to OPEN/FAIL if CODE_LEN=1).
- ENTRY: each key_valid compares against digit[digit_cnt]; any mismatch sets sticky mismatch flag; entry always collects all CODE_LEN digits (no early reject). On CODE_LEN-th digit: mismatch clear → OPEN, else FAIL.
- ENTRY timeout: TIMEOUT_CYCLES consecutive cycles with no key_valid → IDLE, entry discarded, fail_cnt unchanged.
- OPEN: unlock=1, fail_cnt cleared on entry, key_valid ignored; after HOLD_CYCLES → IDLE.
- FAIL: fail=1, fail_cnt increments on entry (saturates at MAX_FAIL); after HOLD_CYCLES → LOCKOUT if fail_cnt==MAX_FAIL, else IDLE.
- LOCKOUT: locked_out=1, key_valid ignored; after LOCKOUT_CYCLES → IDLE, fail_cnt cleared.
- digit_cnt cleared on every transition into IDLE, OPEN, FAIL.
- Code register reset to CODE; digit i = code[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W].
- Outputs are Moore decodes of registered state; only one of unlock/fail/locked_out/prog_busy high at a time.

## Timing
- Reset (async assert, sync to clk on deassert by system): state IDLE, all outputs 0, counters 0, code=CODE.
- key_valid sampled at edge t with final digit → unlock or fail high from edge t (first cycle after t) for exactly HOLD_CYCLES cycles.
- Lockout begins the cycle after fail drops; lasts exactly LOCKOUT_CYCLES.
- Timeout counter reset by each accepted key_valid; abort at count TIMEOUT_CYCLES.
- key_valid and timeout expiry in same cycle: key wins.
- Held key_valid (multi-cycle) counts as one digit per asserted cycle; debouncing is upstream.
- rst_n low mid-operation: immediate return to reset values, including any programmed code.

## Configuration
- KEYPAD_LOCK_PROG_EN defined: in OPEN, prog_req → PROG (unlock drops, prog_busy=1). Next CODE_LEN key_valid digits fill a shadow register; on the last digit the code register is replaced, state → IDLE. TIMEOUT_CYCLES without a digit in PROG → IDLE, code unchanged. prog_req outside OPEN ignored.
- Undefined: prog_req ignored, prog_busy tied 0, code fixed at CODE (no code register).

## Test plan
- Reset, keys 0,1,5 on consecutive cycles → unlock high 200 cycles starting cycle after '5', fail_cnt=0, then IDLE.
- Keys 0,2,5 → fail high 200 cycles, fail_cnt=1; unlock never asserts.
- Three wrong entries → fail_cnt=3, locked_out high 5000 cycles after third fail; keys 0,1,5 during lockout ignored; afterwards fail_cnt=0 and 0,1,5 unlocks.
- Keys 0,1 then 1000 idle cycles → IDLE, digit_cnt=0, fail_cnt unchanged; subsequent 0,1,5 unlocks.
- With KEYPAD_LOCK_PROG_EN: unlock via 0,1,5, prog_req, keys 7,7,3 → code=12'h773; 0,1,5 now fails, 7,7,3 unlocks; rst_n pulse restores 12'h015.
- rst_n asserted mid-unlock and mid-lockout → outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/keypad_lock.sv
// keypad_lock: N-digit keypad code lock with held unlock/fail indications, failure lockout and entry timeout.
// Define KEYPAD_LOCK_PROG_EN to allow a new code to be entered from OPEN via prog_req.
module keypad_lock #(
    parameter int unsigned                  CODE_LEN       = 3,
    parameter int unsigned                  DIGIT_W        = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0]  CODE           = 12'h015,
    parameter int unsigned                  HOLD_CYCLES    = 200,
    parameter int unsigned                  TIMEOUT_CYCLES = 1000,
    parameter int unsigned                  MAX_FAIL       = 3,
    parameter int unsigned                  LOCKOUT_CYCLES = 5000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             key_valid,
    input  logic [DIGIT_W-1:0]               key_num,
    input  logic                             prog_req,
    output logic                             unlock,
    output logic                             fail,
    output logic                             locked_out,
    output logic                             prog_busy,
    output logic [$clog2(CODE_LEN+1)-1:0]    digit_cnt,
    output logic [$clog2(MAX_FAIL+1)-1:0]    fail_cnt
);
    localparam int unsigned CODE_W  = CODE_LEN * DIGIT_W;
    localparam int unsigned DC_W    = $clog2(CODE_LEN + 1);
    localparam int unsigned FC_W    = $clog2(MAX_FAIL + 1);
    localparam int unsigned MAX_HT  = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_HT > LOCKOUT_CYCLES) ? MAX_HT : LOCKOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [DC_W-1:0]  DIG_LAST  = DC_W'(CODE_LEN - 1);
    localparam logic [FC_W-1:0]  FAIL_MAX  = FC_W'(MAX_FAIL);

    typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_OPEN, S_FAIL, S_LOCKOUT, S_PROG} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DC_W-1:0]   digit_cnt_q;
    logic [FC_W-1:0]   fail_cnt_q;
    logic              mism_q;
    logic              unlock_q, fail_q, locked_q;
    logic [CODE_W-1:0] code_cur;
    logic [DIGIT_W-1:0] exp_digit;
    logic              miss_d;
    logic              is_last;

`ifdef KEYPAD_LOCK_PROG_EN
    logic [CODE_W-1:0] code_q, shadow_q, shadow_d;
    logic              prog_busy_q;

    assign code_cur  = code_q;
    assign shadow_d  = CODE_W'({shadow_q, key_num});
    assign prog_busy = prog_busy_q;
`else
    logic unused_prog_req;

    assign unused_prog_req = prog_req;
    assign code_cur        = CODE;
    assign prog_busy       = 1'b0;
`endif

    always_comb begin
        exp_digit = '0;
        for (int unsigned i = 0; i < CODE_LEN; i++) begin
            if (DC_W'(i) == digit_cnt_q) exp_digit = code_cur[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
        end
    end

    // digit_cnt_q is 0 in IDLE, so IDLE and ENTRY share the same key handling
    assign miss_d  = (key_num != exp_digit) | ((state_q == S_ENTRY) & mism_q);
    assign is_last = (digit_cnt_q == DIG_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            digit_cnt_q <= '0;
            fail_cnt_q  <= '0;
            mism_q      <= 1'b0;
            unlock_q    <= 1'b0;
            fail_q      <= 1'b0;
            locked_q    <= 1'b0;
`ifdef KEYPAD_LOCK_PROG_EN
            code_q      <= CODE;
            shadow_q    <= '0;
            prog_busy_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_ENTRY: begin
                    if (key_valid) begin
                        cnt_q <= '0;
                        if (is_last) begin
                            digit_cnt_q <= '0;
                            mism_q      <= 1'b0;
                            if (miss_d) begin
                                state_q <= S_FAIL;
                                fail_q  <= 1'b1;
                                if (fail_cnt_q != FAIL_MAX) fail_cnt_q <= fail_cnt_q + 1'b1;
                            end else begin
                                state_q    <= S_OPEN;
                                unlock_q   <= 1'b1;
                                fail_cnt_q <= '0;
                            end
                        end else begin
                            state_q     <= S_ENTRY;
                            digit_cnt_q <= digit_cnt_q + 1'b1;
                            mism_q      <= miss_d;
                        end
                    end else if (state_q == S_ENTRY) begin
                        if (cnt_q == TO_LAST) begin
                            state_q     <= S_IDLE;
                            cnt_q       <= '0;
                            digit_cnt_q <= '0;
                            mism_q      <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_OPEN: begin
`ifdef KEYPAD_LOCK_PROG_EN
                    if (prog_req) begin
                        state_q     <= S_PROG;
                        unlock_q    <= 1'b0;
                        prog_busy_q <= 1'b1;
                        cnt_q       <= '0;
                    end else
`endif
                    if (cnt_q == HOLD_LAST) begin
                        state_q  <= S_IDLE;
                        unlock_q <= 1'b0;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_FAIL: begin
                    if (cnt_q == HOLD_LAST) begin
                        fail_q <= 1'b0;
                        cnt_q  <= '0;
                        if (fail_cnt_q == FAIL_MAX) begin
                            state_q  <= S_LOCKOUT;
                            locked_q <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_LOCKOUT: begin
                    if (cnt_q == LOCK_LAST) begin
                        state_q    <= S_IDLE;
                        locked_q   <= 1'b0;
                        fail_cnt_q <= '0;
                        cnt_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`ifdef KEYPAD_LOCK_PROG_EN
                S_PROG: begin
                    if (key_valid) begin
                        cnt_q    <= '0;
                        shadow_q <= shadow_d;
                        if (is_last) begin
                            code_q      <= shadow_d;
                            state_q     <= S_IDLE;
                            prog_busy_q <= 1'b0;
                            digit_cnt_q <= '0;
                        end else begin
                            digit_cnt_q <= digit_cnt_q + 1'b1;
                        end
                    end else if (cnt_q == TO_LAST) begin
                        state_q     <= S_IDLE;
                        prog_busy_q <= 1'b0;
                        digit_cnt_q <= '0;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                default: begin
                    state_q     <= S_IDLE;
                    cnt_q       <= '0;
                    digit_cnt_q <= '0;
                    mism_q      <= 1'b0;
                    unlock_q    <= 1'b0;
                    fail_q      <= 1'b0;
                    locked_q    <= 1'b0;
                end
            endcase
        end
    end

    assign unlock     = unlock_q;
    assign fail       = fail_q;
    assign locked_out = locked_q;
    assign digit_cnt  = digit_cnt_q;
    assign fail_cnt   = fail_cnt_q;
endmodule
